// File: rtl/map_pkg.sv
// Shared constants and FSM encoding for the writable game-map store.
package map_pkg;

  localparam int unsigned FILL_BORDER  = 0;
  localparam int unsigned FILL_PATTERN = 1;
  localparam int unsigned CELL_EMPTY   = 0;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } map_state_t;

  // Wall cell value is all ones for the configured cell width.
  function automatic int unsigned cell_wall(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/map_fill_gen.sv
// Combinational map generator: (row, col) -> initial cell value for the chosen fill mode.
module map_fill_gen
  import map_pkg::*;
#(
  parameter int unsigned ROW_BITS  = 4,
  parameter int unsigned COL_BITS  = 4,
  parameter int unsigned BITS      = 2,
  parameter int unsigned FILL_MODE = FILL_BORDER
) (
  input  logic [ROW_BITS-1:0] i_row,
  input  logic [COL_BITS-1:0] i_col,
  output logic [BITS-1:0]     o_cell
);

  localparam int unsigned ROWS = 1 << ROW_BITS;
  localparam int unsigned COLS = 1 << COL_BITS;
  localparam logic [BITS-1:0] WALL  = BITS'(cell_wall(BITS));
  localparam logic [BITS-1:0] EMPTY = BITS'(CELL_EMPTY);

  int unsigned w_r;
  int unsigned w_c;
  logic        w_border;
  logic        w_diag;
  logic        w_pillar;

  assign w_r = 32'(i_row);
  assign w_c = 32'(i_col);

  assign w_border = (w_r == 0) || (w_r == ROWS - 1) || (w_c == 0) || (w_c == COLS - 1);
  // Within the 8x8 corner, ~row[2:0] == col[2:0] is the anti-diagonal row + col == 7.
  assign w_diag   = (w_r < 8) && (w_c < 8) && ((7 - w_r) == w_c);
  assign w_pillar = ((w_r % 4) == 2) && ((w_c % 4) == 2);

  always_comb begin
    o_cell = EMPTY;
    if (w_border || ((FILL_MODE == FILL_PATTERN) && (w_diag || w_pillar)))
      o_cell = WALL;
  end

endmodule

// File: rtl/map_ram.sv
// Writable game-map store: fill engine after reset/init_req, 1-cycle registered reads, host write port.
module map_ram
  import map_pkg::*;
#(
  parameter int unsigned ROW_BITS    = 4,
  parameter int unsigned COL_BITS    = 4,
  parameter int unsigned BITS        = 2,
  parameter int unsigned FILL_MODE   = 0,
  parameter int unsigned LOCK_BORDER = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                init_req,
  output logic                busy,
  output logic                fill_done,
  input  logic                rd_en,
  input  logic [ROW_BITS-1:0] rd_row,
  input  logic [COL_BITS-1:0] rd_col,
  output logic                rd_valid,
  output logic [BITS-1:0]     rd_val,
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] wr_row,
  input  logic [COL_BITS-1:0] wr_col,
  input  logic [BITS-1:0]     wr_val,
  output logic                wr_ready
);

  localparam int unsigned IDX_W = ROW_BITS + COL_BITS;
  localparam int unsigned CELLS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  logic [BITS-1:0]  r_mem [CELLS];
  map_state_t       r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_fill_done;
  logic             r_rd_valid;
  logic [BITS-1:0]  r_rd_val;

  logic [BITS-1:0]  w_fill_cell;
  logic [BITS-1:0]  w_wr_edge_cell;
  logic             w_wr_border;
  logic             w_wr_accept;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  map_fill_gen #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS),
    .BITS     (BITS),
    .FILL_MODE(FILL_MODE)
  ) u_fill_gen (
    .i_row (r_cnt[IDX_W-1:COL_BITS]),
    .i_col (r_cnt[COL_BITS-1:0]),
    .o_cell(w_fill_cell)
  );

  // Border-only generator doubles as the outer-edge detector for locked writes.
  map_fill_gen #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS),
    .BITS     (BITS),
    .FILL_MODE(FILL_BORDER)
  ) u_border_gen (
    .i_row (wr_row),
    .i_col (wr_col),
    .o_cell(w_wr_edge_cell)
  );

  assign w_wr_idx    = {wr_row, wr_col};
  assign w_rd_idx    = {rd_row, rd_col};
  assign w_wr_border = (w_wr_edge_cell != '0);
  assign w_wr_accept = wr_en && (r_state == ST_IDLE) && !((LOCK_BORDER != 0) && w_wr_border);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_FILL;
      r_cnt       <= '0;
      r_busy      <= 1'b1;
      r_fill_done <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_val    <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en)
        r_rd_val <= r_mem[w_rd_idx];
      case (r_state)
        ST_FILL: begin
          r_fill_done <= 1'b0;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_fill_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_fill_done <= 1'b0;
          if (init_req) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_FILL;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the fill pass rewrites every cell.
  always_ff @(posedge clk) begin
    if (r_state == ST_FILL)
      r_mem[r_cnt] <= w_fill_cell;
    else if (w_wr_accept)
      r_mem[w_wr_idx] <= wr_val;
  end

  assign busy      = r_busy;
  assign fill_done = r_fill_done;
  assign rd_valid  = r_rd_valid;
  assign rd_val    = r_rd_val;
  assign wr_ready  = !r_busy;

endmodule

// File: tb/tb_map_ram.sv
// Bench for map_ram: two instances (border map with locked edges, pattern map with unlocked edges)
// driven in lockstep and compared against an array-based model of the map.
module tb_map_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       init_req;
  logic       rd_en;
  logic       wr_en;
  logic [3:0] rd_row, rd_col, wr_row, wr_col;
  logic [1:0] wr_val;

  logic [1:0] busy_o, fd_o, rdv_o, wrr_o;
  logic [1:0] rdval_o [2];

  map_ram #(.FILL_MODE(0), .LOCK_BORDER(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .init_req(init_req),
    .busy(busy_o[0]), .fill_done(fd_o[0]),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rdv_o[0]), .rd_val(rdval_o[0]),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
    .wr_ready(wrr_o[0])
  );

  map_ram #(.FILL_MODE(1), .LOCK_BORDER(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .init_req(init_req),
    .busy(busy_o[1]), .fill_done(fd_o[1]),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rdv_o[1]), .rd_val(rdval_o[1]),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
    .wr_ready(wrr_o[1])
  );

  int tests = 0;
  int fails = 0;

  // Model: map contents per instance (-1 = unknown), cells left to fill, expected read data.
  int mdl [2][256];
  int mleft;
  int rexp [2];
  bit fd_exp;

  typedef struct {
    int r;
    int c;
    int e0;
    int e1;
  } rd_vec_t;

  rd_vec_t vecs [7];

  task automatic check(input string name, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
    end
  endtask

  function automatic bit is_border(input int r, input int c);
    return (r == 0) || (r == 15) || (c == 0) || (c == 15);
  endfunction

  // Instance d uses FILL_MODE = d.
  function automatic int fill_cell(input int d, input int r, input int c);
    if (is_border(r, c)) return 3;
    if (d == 1) begin
      if (r < 8 && c < 8 && r + c == 7) return 3;
      if (r % 4 == 2 && c % 4 == 2) return 3;
    end
    return 0;
  endfunction

  // One clock: drive inputs, advance the model, then check every output of both instances.
  task automatic cyc(input bit we, input int wr, input int wc, input int wv,
                     input bit re, input int rr, input int rc, input bit ini);
    bit acc_idle;
    int idx;
    wr_en    = we;
    wr_row   = 4'(wr);
    wr_col   = 4'(wc);
    wr_val   = 2'(wv);
    rd_en    = re;
    rd_row   = 4'(rr);
    rd_col   = 4'(rc);
    init_req = ini;
    for (int d = 0; d < 2; d++)
      if (re) rexp[d] = mdl[d][rr*16 + rc];
    acc_idle = (mleft == 0);
    fd_exp   = 1'b0;
    if (mleft > 0) begin
      idx = 256 - mleft;
      for (int d = 0; d < 2; d++) mdl[d][idx] = fill_cell(d, idx / 16, idx % 16);
      mleft--;
      if (mleft == 0) fd_exp = 1'b1;
    end else if (ini) begin
      mleft = 256;
    end
    if (we && acc_idle)
      for (int d = 0; d < 2; d++)
        if (!(d == 0 && is_border(wr, wc))) mdl[d][wr*16 + wc] = wv;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("busy", d, int'(busy_o[d]), (mleft > 0) ? 1 : 0);
      check("wr_ready", d, int'(wrr_o[d]), (mleft > 0) ? 0 : 1);
      check("fill_done", d, int'(fd_o[d]), int'(fd_exp));
      check("rd_valid", d, int'(rdv_o[d]), int'(re));
      if (rexp[d] >= 0) check("rd_val", d, int'(rdval_o[d]), rexp[d]);
    end
    wr_en = 1'b0; rd_en = 1'b0; init_req = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int r, input int c);
    cyc(0, 0, 0, 0, 1, r, c, 0);
  endtask

  task automatic wr(input int r, input int c, input int v);
    cyc(1, r, c, v, 0, 0, 0, 0);
  endtask

  // Count busy cycles until the fill ends; optionally inject init_req / a write at a given cycle.
  task automatic wait_fill(input string name, input int init_at, input int wr_at);
    int n;
    n = 0;
    while (busy_o[0] && n < 400) begin
      if (n == wr_at) cyc(1, 2, 2, 2, 0, 0, 0, 0);
      else            cyc(0, 0, 0, 0, 0, 0, 0, (n == init_at));
      n++;
    end
    check(name, 0, n, 256);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_busy"}, d, int'(busy_o[d]), 1);
      check({tag, "_fill_done"}, d, int'(fd_o[d]), 0);
      check({tag, "_rd_valid"}, d, int'(rdv_o[d]), 0);
      check({tag, "_rd_val"}, d, int'(rdval_o[d]), 0);
    end
  endtask

  initial begin
    vecs[0] = '{r: 0,  c: 0,  e0: 3, e1: 3};
    vecs[1] = '{r: 15, c: 7,  e0: 3, e1: 3};
    vecs[2] = '{r: 5,  c: 5,  e0: 0, e1: 0};
    vecs[3] = '{r: 1,  c: 6,  e0: 0, e1: 3};
    vecs[4] = '{r: 10, c: 10, e0: 0, e1: 3};
    vecs[5] = '{r: 9,  c: 9,  e0: 0, e1: 0};
    vecs[6] = '{r: 0,  c: 9,  e0: 3, e1: 3};

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mdl[d][i] = -1;
      rexp[d] = 0;
    end
    mleft  = 256;
    fd_exp = 1'b0;
    reset_n = 1'b0; init_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_row = '0; rd_col = '0; wr_row = '0; wr_col = '0; wr_val = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;
    wait_fill("busy_len_reset", -1, -1);

    // Generated map contents, both fill modes.
    for (int i = 0; i < 7; i++) begin
      rd(vecs[i].r, vecs[i].c);
      check("vec_rd_val", 0, int'(rdval_o[0]), vecs[i].e0);
      check("vec_rd_val", 1, int'(rdval_o[1]), vecs[i].e1);
    end

    // Write then read back.
    wr(3, 4, 2);
    rd(3, 4);
    check("wr_rd_34", 0, int'(rdval_o[0]), 2);

    // Same-edge read and write returns the old value.
    cyc(1, 3, 4, 1, 1, 3, 4, 0);
    check("rbw_old", 0, int'(rdval_o[0]), 2);
    rd(3, 4);
    check("rbw_new", 0, int'(rdval_o[0]), 1);

    // Border write: dropped on the locked instance, taken on the unlocked one.
    wr(0, 7, 0);
    rd(0, 7);
    check("lock_border", 0, int'(rdval_o[0]), 3);
    check("unlock_border", 1, int'(rdval_o[1]), 0);

    // Reset in the middle of a fill at index 100.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 99; i++) idle_cyc();
    rd(0, 0);
    reset_n = 1'b0;
    #1;
    mleft = 256;
    for (int d = 0; d < 2; d++) rexp[d] = 0;
    check_reset_state("midfill_reset");
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) mdl[d][0] = fill_cell(d, 0, 0);
    reset_n = 1'b1;
    // init_req mid-fill must not extend busy; a write while busy must be dropped.
    wait_fill("busy_len_refill", 50, 200);
    rd(2, 2);
    check("busy_write_dropped", 0, int'(rdval_o[0]), 0);

    // init_req in idle restores the generated map over host edits.
    wr(3, 4, 2);
    rd(3, 4);
    check("pre_init_34", 0, int'(rdval_o[0]), 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    wait_fill("busy_len_init", -1, -1);
    rd(3, 4);
    check("post_init_34", 0, int'(rdval_o[0]), 0);

    // Randomised traffic, including occasional refills.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
          ($urandom_range(0, 149) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
